// File: rtl/tlm_pair_streamer_pkg.sv
// Shared types and helpers for the pair streamer.
// - tlm_state_e : streamer FSM states
// - NUM_DEF / ITEM_WIDTH_DEF / BATCH_W : default batch geometry
// - pair_sel()  : reference {A,B} extraction for the default geometry
package tlm_stream_pkg;

  localparam int NUM_DEF        = 50;
  localparam int ITEM_WIDTH_DEF = 8;
  localparam int BATCH_W        = NUM_DEF * 2 * ITEM_WIDTH_DEF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } tlm_state_e;

  // Pair k is item 2k (A) and item 2k+1 (B); A lands in the upper half.
  function automatic logic [2*ITEM_WIDTH_DEF-1:0] pair_sel(
    input logic [BATCH_W-1:0] payload,
    input int unsigned        idx
  );
    return {payload[(2*idx)*ITEM_WIDTH_DEF +: ITEM_WIDTH_DEF],
            payload[(2*idx+1)*ITEM_WIDTH_DEF +: ITEM_WIDTH_DEF]};
  endfunction

endpackage

// File: rtl/tlm_pair_streamer_if.sv
// Operand-pair stream between the streamer and its consumer (the BFM).
// - a_o / b_o : operand A / operand B
// - valid_o   : pair is valid
// - ready_i   : consumer takes the pair this cycle
// Signal names follow the streamer's port view.
interface tlm_pair_if #(
  parameter int ITEM_WIDTH = 8
);
  logic [ITEM_WIDTH-1:0] a_o;
  logic [ITEM_WIDTH-1:0] b_o;
  logic                  valid_o;
  logic                  ready_i;

  modport master (output a_o, output b_o, output valid_o, input ready_i);
  modport slave  (input a_o, input b_o, input valid_o, output ready_i);
endinterface

// File: rtl/tlm_pair_streamer_select.sv
// Combinational pair extraction: picks pair idx_i out of a packed batch.
// - payload_i : packed batch, item i at [i*ITEM_WIDTH +: ITEM_WIDTH]
// - idx_i     : pair index; out-of-range indices yield zero
// - a_o / b_o : item[2*idx] / item[2*idx+1]
module tlm_pair_select #(
  parameter int NUM        = 50,
  parameter int ITEM_WIDTH = 8,
  parameter int IDX_W      = 6
) (
  input  logic [NUM*2*ITEM_WIDTH-1:0] payload_i,
  input  logic [IDX_W-1:0]            idx_i,
  output logic [ITEM_WIDTH-1:0]       a_o,
  output logic [ITEM_WIDTH-1:0]       b_o
);

  // Explicit compare-mux so an index past NUM-1 (the "next" index on the
  // last beat) never reads outside the payload.
  always_comb begin
    a_o = '0;
    b_o = '0;
    for (int i = 0; i < NUM; i++) begin
      if (idx_i == IDX_W'(i)) begin
        a_o = payload_i[(2*i)*ITEM_WIDTH   +: ITEM_WIDTH];
        b_o = payload_i[(2*i+1)*ITEM_WIDTH +: ITEM_WIDTH];
      end
    end
  end

endmodule

// File: rtl/tlm_pair_streamer.sv
// Plays a captured batch of NUM operand pairs out one pair per accepted beat.
// - clk_i, reset_i : clock, synchronous active-low reset
// - load_i, payload_i, load_ready_o : batch offer / packed batch / can accept
// - pair_if (master) : a_o, b_o, valid_o out; ready_i in
// - busy_o  : batch in flight
// - done_o  : one-cycle pulse after the last pair is taken
// - batch_cnt_o : completed batches, wraps at 2^16
module tlm_pair_streamer
  import tlm_stream_pkg::*;
#(
  parameter int NUM        = 50,
  parameter int ITEM_WIDTH = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        load_i,
  input  logic [NUM*2*ITEM_WIDTH-1:0] payload_i,
  output logic                        load_ready_o,
  tlm_pair_if.master                  pair_if,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [15:0]                 batch_cnt_o
);

  localparam int PAY_W = NUM * 2 * ITEM_WIDTH;
  localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;

  tlm_state_e             state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [PAY_W-1:0]       payload_q;
  logic [ITEM_WIDTH-1:0]  a_q, b_q;
  logic                   valid_q, busy_q, done_q;
  logic [15:0]            cnt_q;

  // One selector serves both cases: in IDLE it looks at the incoming
  // payload (pair 0 for a load), otherwise at the held payload one pair
  // ahead so a_q/b_q can be registered on the handshake edge.
  logic [PAY_W-1:0]       sel_payload;
  logic [IDX_W-1:0]       sel_idx;
  logic [ITEM_WIDTH-1:0]  a_d, b_d;
  logic                   last_beat;

  assign sel_payload = (state_q == S_IDLE) ? payload_i : payload_q;
  assign sel_idx     = (state_q == S_IDLE) ? '0 : idx_q + IDX_W'(1);
  assign last_beat   = (idx_q == IDX_W'(NUM - 1));

  tlm_pair_select #(
    .NUM        (NUM),
    .ITEM_WIDTH (ITEM_WIDTH),
    .IDX_W      (IDX_W)
  ) u_sel (
    .payload_i (sel_payload),
    .idx_i     (sel_idx),
    .a_o       (a_d),
    .b_o       (b_d)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      payload_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (load_i) begin
            payload_q <= payload_i;
            idx_q     <= '0;
            a_q       <= a_d;
            b_q       <= b_d;
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (pair_if.ready_i) begin
            if (last_beat) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              cnt_q   <= cnt_q + 16'd1;
              state_q <= S_DONE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
              a_q   <= a_d;
              b_q   <= b_d;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready_o    = (state_q == S_IDLE);
  assign pair_if.a_o     = a_q;
  assign pair_if.b_o     = b_q;
  assign pair_if.valid_o = valid_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign batch_cnt_o     = cnt_q;

endmodule

// File: tb/tb_tlm_pair_streamer.sv
// Randomized bench with a queue-based reference model and a negedge monitor.
module tb_tlm_pair_streamer;

  localparam int NUM = 50;
  localparam int IW  = 8;
  localparam int BW  = NUM * 2 * IW;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          load_i = 1'b0;
  logic [BW-1:0] payload_i = '0;
  logic          load_ready_o, busy_o, done_o;
  logic [15:0]   batch_cnt_o;

  tlm_pair_if #(.ITEM_WIDTH(IW)) pif ();

  tlm_pair_streamer #(.NUM(NUM), .ITEM_WIDTH(IW)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .load_i       (load_i),
    .payload_i    (payload_i),
    .load_ready_o (load_ready_o),
    .pair_if      (pif),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .batch_cnt_o  (batch_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending pairs of the accepted batch, {A,B}; a done pulse is due the
  // cycle after the queue drains; the streamer is idle otherwise.
  logic [2*IW-1:0] q[$];
  bit              exp_done_now = 0, exp_done_next = 0;
  logic [15:0]     cnt_model = 0;
  int              batch_pops = 0;
  int              n_loaded = 0;
  bit              idle;

  function automatic logic [IW-1:0] item(input logic [BW-1:0] p, input int i);
    return p[i*IW +: IW];
  endfunction

  always @(negedge clk_i) begin
    if (!reset_i) begin
      q.delete();
      exp_done_now  = 0;
      exp_done_next = 0;
      cnt_model     = 0;
      batch_pops    = 0;
    end else begin
      idle = (q.size() == 0) && !exp_done_now;
      if (exp_done_now) cnt_model = cnt_model + 16'd1;
      chk("done", 64'(done_o), 64'(exp_done_now));
      chk("load_ready", 64'(load_ready_o), 64'(idle));
      chk("valid", 64'(pif.valid_o), 64'(q.size() != 0));
      chk("busy", 64'(busy_o), 64'(q.size() != 0));
      chk("batch_cnt", 64'(batch_cnt_o), 64'(cnt_model));
      if (q.size() != 0 && pif.valid_o) begin
        chk("pair", 64'({pif.a_o, pif.b_o}), 64'(q[0]));
        if (pif.ready_i) begin
          void'(q.pop_front());
          batch_pops++;
          if (q.size() == 0) exp_done_next = 1;
        end
      end
      if (idle && load_i) begin
        for (int k = 0; k < NUM; k++)
          q.push_back({item(payload_i, 2*k), item(payload_i, 2*k+1)});
        batch_pops = 0;
        n_loaded++;
      end
      exp_done_now  = exp_done_next;
      exp_done_next = 0;
    end
  end

  // ---------------- ready driver ----------------
  int rmode = 0;  // 0: always 1, 1: toggle, 2: random
  initial begin
    pif.ready_i = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      case (rmode)
        0:       pif.ready_i = 1'b1;
        1:       pif.ready_i = ~pif.ready_i;
        default: pif.ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [BW-1:0] mk(input int mode);
    logic [BW-1:0] p;
    for (int i = 0; i < 2*NUM; i++)
      case (mode)
        0:       p[i*IW +: IW] = IW'(i);
        1:       p[i*IW +: IW] = '1;
        default: p[i*IW +: IW] = IW'($urandom);
      endcase
    return p;
  endfunction

  task automatic load_batch(input logic [BW-1:0] p);
    int target;
    target = n_loaded + 1;
    @(posedge clk_i); #1;
    payload_i = p;
    load_i    = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk_i); #1;
      if (n_loaded >= target) begin
        load_i = 1'b0;
        return;
      end
    end
    load_i = 1'b0;
    chk("load_timeout", 64'(n_loaded), 64'(target));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_i); #1;
      if (q.size() == 0 && !exp_done_now) return;
    end
    chk("idle_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_i); #1;
      if (batch_pops >= n) return;
    end
    chk("beat_timeout", 64'(batch_pops), 64'(n));
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    repeat (cycles) @(posedge clk_i);
    #1 reset_i = 1'b1;
  endtask

  initial begin
    // 1. reset held for three edges
    repeat (3) begin
      @(negedge clk_i); #1;
      chk("rst_load_ready", 64'(load_ready_o), 64'd1);
      chk("rst_valid", 64'(pif.valid_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_cnt", 64'(batch_cnt_o), 64'd0);
      chk("rst_ab", 64'({pif.a_o, pif.b_o}), 64'd0);
    end
    reset_i = 1'b1;

    // 2. item i = i, full throughput
    rmode = 0;
    load_batch(mk(0));
    wait_idle();
    chk("cnt_after_1", 64'(batch_cnt_o), 64'd1);

    // 3. same batch, ready toggling
    rmode = 1;
    load_batch(mk(0));
    wait_idle();
    chk("cnt_after_2", 64'(batch_cnt_o), 64'd2);

    // 4. load offered mid-batch with all-0xFF payload must be ignored
    rmode = 0;
    load_batch(mk(0));
    wait_beats(10);
    @(posedge clk_i); #1;
    payload_i = mk(1);
    load_i    = 1'b1;
    @(posedge clk_i); #1;
    load_i    = 1'b0;
    wait_idle();
    chk("cnt_after_3", 64'(batch_cnt_o), 64'd3);

    // 5. reset mid-batch, then a fresh random batch restarts at pair 0
    load_batch(mk(0));
    wait_beats(25);
    do_reset(1);
    @(negedge clk_i); #1;
    chk("midrst_valid", 64'(pif.valid_o), 64'd0);
    chk("midrst_cnt", 64'(batch_cnt_o), 64'd0);
    chk("midrst_load_ready", 64'(load_ready_o), 64'd1);
    rmode = 2;
    load_batch(mk(2));
    wait_idle();
    chk("cnt_after_fresh", 64'(batch_cnt_o), 64'd1);

    // 6. three back-to-back batches with load_i held high
    do_reset(2);
    rmode = 2;
    begin
      int target;
      target = n_loaded + 3;
      @(posedge clk_i); #1;
      load_i = 1'b1;
      for (int i = 0; i < 2000; i++) begin
        payload_i = mk(2);
        @(posedge clk_i); #1;
        if (n_loaded >= target) break;
      end
      load_i = 1'b0;
      chk("b2b_loads", 64'(n_loaded), 64'(target));
    end
    wait_idle();
    chk("cnt_after_b2b", 64'(batch_cnt_o), 64'd3);

    repeat (3) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
